// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - control-bit indices, shift encodings and FSM states for alu_seq
package alu_pkg;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational zx/nx/zy/ny/f/no function; carry port exists only with ALU_FLAGS_EN
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       c,
  output logic [WIDTH-1:0] res
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry
`endif
);

  logic [WIDTH-1:0] inx, iny, ax, ay, sum, val;

  always_comb begin
    inx = c[ZX] ? '0 : x;
    ax  = c[NX] ? ~inx : inx;
    iny = c[ZY] ? '0 : y;
    ay  = c[NY] ? ~iny : iny;
  end

`ifdef ALU_FLAGS_EN
  logic sum_c;
  always_comb begin
    {sum_c, sum} = {1'b0, ax} + {1'b0, ay};
    // carry reflects the adder only, independent of the output inversion
    carry = c[F] & sum_c;
  end
`else
  always_comb sum = ax + ay;
`endif

  always_comb begin
    val = c[F] ? sum : (ax & ay);
    res = c[NO] ? ~val : val;
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with multi-cycle shift and valid/ready handshakes; flags built with ALU_FLAGS_EN
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       c,
  input  logic [1:0]       sh,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       sh_q, sh_d;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] shifted;

`ifdef ALU_FLAGS_EN
  logic core_carry;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x     (x),
    .y     (y),
    .c     (c),
    .res   (core_res)
`ifdef ALU_FLAGS_EN
    ,
    .carry (core_carry)
`endif
  );

  always_comb begin
    case (sh_q)
      SH_SHL:  shifted = {acc_q[WIDTH-2:0], 1'b0};
      SH_LSR:  shifted = {1'b0, acc_q[WIDTH-1:1]};
      SH_ASR:  shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d  = sh;
          acc_d = core_res;
          if (sh == SH_NONE || shamt == '0) begin
            state_d = DONE;
          end else begin
            count_d = shamt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d   = shifted;
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sh_q    <= SH_NONE;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sh_q    <= sh_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = acc_q;

`ifdef ALU_FLAGS_EN
  logic shift_out, enter_done;
  logic c_reg_q, c_reg_d;
  logic flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_c_q, flag_c_d;

  // shl drops the msb; both right shifts drop the lsb
  assign shift_out  = (sh_q == SH_SHL) ? acc_q[WIDTH-1] : acc_q[0];
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_comb begin
    c_reg_d  = c_reg_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    if (state_q == IDLE && in_valid) c_reg_d = core_carry;
    else if (state_q == SHIFT)       c_reg_d = shift_out;
    if (enter_done) begin
      flag_z_d = (acc_d == '0);
      flag_n_d = acc_d[WIDTH-1];
      flag_c_d = c_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_reg_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      c_reg_q  <= c_reg_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
